// File: rtl/fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream
//
// Read-side consumer for the async FIFO, living in the read clock domain.
// It pops words from a first-word-fall-through FIFO read port and
// re-presents them on a valid/ready stream through a two-entry skid buffer.
// The skid entry lets the FIFO increment be decoded from registered state
// alone, so sink back-pressure never reaches FIFO_RINC combinationally.
// A running count of words accepted by the sink is kept in WORD_CNT.
//
// Parameters
//   DATA_WIDTH  word width, equal to the FIFO data width
//   CNT_WIDTH   width of the delivered-word counter (wraps modulo 2^CNT_WIDTH)
//
// Ports
//   CLK         read-domain clock (same as the FIFO read clock)
//   RST         asynchronous active-low reset
//   ENABLE      allows new pops; buffered words drain regardless
//   FIFO_EMPTY  FIFO empty flag
//   FIFO_RDATA  FIFO head word, valid whenever FIFO_EMPTY is low
//   FIFO_RINC   FIFO pop strobe, one word per high cycle
//   OUT_DATA    stream data (driven by the main register)
//   OUT_VALID   stream valid
//   OUT_READY   stream ready from the sink
//   WORD_CNT    number of words accepted by the sink
// ---------------------------------------------------------------------------
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENABLE,
  input  logic                  FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] FIFO_RDATA,
  output logic                  FIFO_RINC,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [CNT_WIDTH-1:0]  WORD_CNT
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] main_d;
  logic [DATA_WIDTH-1:0] skid_q;
  logic [DATA_WIDTH-1:0] skid_d;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  push;
  logic                  pop;

  // Pop decision uses registered state and FIFO inputs only. RST is folded
  // in so the strobe is held low for the whole reset interval, and the
  // empty term makes an underflow impossible.
  assign push      = RST & ENABLE & ~FIFO_EMPTY & (state_q != S_TWO);
  assign FIFO_RINC = push;

  assign OUT_VALID = (state_q != S_EMPTY);
  assign OUT_DATA  = main_q;
  assign WORD_CNT  = cnt_q;
  assign pop       = OUT_VALID & OUT_READY;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      S_EMPTY: begin
        if (push) begin
          state_d = S_ONE;
          main_d  = FIFO_RDATA;
        end
      end
      S_ONE: begin
        if (push && pop) begin
          // Sink takes the current word while the next one lands in main.
          main_d = FIFO_RDATA;
        end else if (push) begin
          state_d = S_TWO;
          skid_d  = FIFO_RDATA;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        // No push is possible here; draining skid takes a full cycle,
        // which is what breaks the ready-to-rinc path.
        if (pop) begin
          state_d = S_ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_stream
//
// Directed bench for fifo_rd_stream with a first-word-fall-through FIFO
// model and a scoreboard queue of expected stream words. The counter is
// configured 4 bits wide so wrap-around is reachable.
// ---------------------------------------------------------------------------
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          ENABLE;
  logic          FIFO_EMPTY;
  logic [DW-1:0] FIFO_RDATA;
  logic          FIFO_RINC;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [CW-1:0] WORD_CNT;

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ENABLE     (ENABLE),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_RDATA (FIFO_RDATA),
    .FIFO_RINC  (FIFO_RINC),
    .OUT_DATA   (OUT_DATA),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .WORD_CNT   (WORD_CNT)
  );

  always #5 CLK = ~CLK;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [CW-1:0] exp_cnt;
  int            vectors = 0;
  int            errs    = 0;
  logic          last_rinc;
  logic          last_valid;
  logic [DW-1:0] last_data;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    FIFO_EMPTY = (fifo_q.size() == 0);
    FIFO_RDATA = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic load(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    refresh();
  endtask

  // One clock cycle: sample and score at the falling edge, then let the
  // FIFO model retire a popped word just after the rising edge.
  task automatic step();
    logic          rinc_s;
    logic          pop_s;
    logic [DW-1:0] d_s;
    logic [DW-1:0] w;
    @(negedge CLK);
    rinc_s     = FIFO_RINC;
    pop_s      = OUT_VALID && OUT_READY;
    d_s        = OUT_DATA;
    last_rinc  = rinc_s;
    last_valid = OUT_VALID;
    last_data  = d_s;
    chk("no_underflow", {15'd0, rinc_s && FIFO_EMPTY}, 16'd0);
    chk("word_cnt", {12'd0, WORD_CNT}, {12'd0, exp_cnt});
    if (pop_s) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 16'(exp_q.size()), 16'd1);
      end else begin
        w = exp_q.pop_front();
        chk("data_order", {8'd0, d_s}, {8'd0, w});
      end
    end
    @(posedge CLK);
    #1;
    if (rinc_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (pop_s) exp_cnt++;
    refresh();
  endtask

  task automatic do_reset();
    RST = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    exp_cnt = '0;
    refresh();
    step();
    chk("rst_valid", {15'd0, OUT_VALID}, 16'd0);
    chk("rst_rinc", {15'd0, FIFO_RINC}, 16'd0);
    step();
    RST = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    int t2_rinc[5] = '{1, 1, 1, 0, 0};
    int t2_val[5]  = '{0, 1, 1, 1, 0};
    int n;

    RST        = 1'b0;
    ENABLE     = 1'b1;
    OUT_READY  = 1'b1;
    FIFO_EMPTY = 1'b1;
    FIFO_RDATA = '0;
    exp_cnt    = '0;
    #1;
    chk("rst_data", {8'd0, OUT_DATA}, 16'd0);
    do_reset();

    // Idle with empty FIFO
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_valid", {15'd0, last_valid}, 16'd0);
      chk("idle_rinc", {15'd0, last_rinc}, 16'd0);
    end

    // Three words, sink always ready
    do_reset();
    load(8'h11); load(8'h22); load(8'h33);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_rinc", {15'd0, last_rinc}, 16'(t2_rinc[i]));
      chk("t2_valid", {15'd0, last_valid}, 16'(t2_val[i]));
    end
    chk("t2_cnt", {12'd0, WORD_CNT}, 16'd3);
    chk("t2_drained", 16'(exp_q.size()), 16'd0);

    // Eight words with a five-cycle stall mid-stream
    do_reset();
    for (int i = 0; i < 8; i++) load(8'hA0 + 8'(i));
    for (int i = 0; i < 3; i++) step();
    OUT_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_stall_rinc", {15'd0, last_rinc}, (i == 0) ? 16'd1 : 16'd0);
      chk("t3_hold_data", {8'd0, last_data}, 16'h00A2);
      chk("t3_hold_valid", {15'd0, last_valid}, 16'd1);
    end
    OUT_READY = 1'b1;
    step();
    chk("t3_skid_drain_rinc", {15'd0, last_rinc}, 16'd0);
    step();
    chk("t3_restart_rinc", {15'd0, last_rinc}, 16'd1);
    n = 0;
    while (exp_q.size() > 0 && n < 30) begin
      step();
      chk("t3_nogap", {15'd0, last_valid}, 16'd1);
      n++;
    end
    chk("t3_drained", 16'(exp_q.size()), 16'd0);
    chk("t3_cnt", {12'd0, WORD_CNT}, 16'd8);

    // ENABLE dropped while both entries are full
    do_reset();
    for (int i = 0; i < 6; i++) load(8'hB0 + 8'(i));
    OUT_READY = 1'b0;
    step(); step();
    ENABLE    = 1'b0;
    OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_rinc_off", {15'd0, last_rinc}, 16'd0);
      chk("t4_valid", {15'd0, last_valid}, (i < 2) ? 16'd1 : 16'd0);
    end
    chk("t4_fifo_left", 16'(fifo_q.size()), 16'd4);
    ENABLE = 1'b1;
    step();
    chk("t4_resume_rinc", {15'd0, last_rinc}, 16'd1);
    drain("t4_drained", 20);
    chk("t4_cnt", {12'd0, WORD_CNT}, 16'd6);

    // Counter wrap with a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) load(8'hC0 + 8'(i));
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      step();
      if (exp_q.size() == 1 && n >= 15 && WORD_CNT != exp_cnt - 4'd1)
        chk("t5_wrap", {12'd0, WORD_CNT}, {12'd0, exp_cnt});
      n++;
    end
    chk("t5_drained", 16'(exp_q.size()), 16'd0);
    chk("t5_cnt", {12'd0, WORD_CNT}, 16'd1);

    // Asynchronous reset with both entries full
    do_reset();
    for (int i = 0; i < 6; i++) load(8'hD0 + 8'(i));
    for (int i = 0; i < 3; i++) step();
    OUT_READY = 1'b0;
    step();
    chk("t6_pre_cnt", {12'd0, WORD_CNT}, 16'd2);
    #2;
    RST = 1'b0;
    #1;
    chk("t6_valid", {15'd0, OUT_VALID}, 16'd0);
    chk("t6_data", {8'd0, OUT_DATA}, 16'd0);
    chk("t6_cnt", {12'd0, WORD_CNT}, 16'd0);
    chk("t6_rinc", {15'd0, FIFO_RINC}, 16'd0);
    exp_q   = fifo_q;
    exp_cnt = '0;
    step();
    RST       = 1'b1;
    OUT_READY = 1'b1;
    step();
    chk("t6_repop", {15'd0, last_rinc}, 16'd1);
    step();
    chk("t6_first", {8'd0, last_data}, 16'h00D4);
    drain("t6_drained", 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side consumer for the async FIFO. Sits in the read clock domain and pops words from the FIFO read port (rempty / rinc / rdata). It re-presents them on a valid/ready stream through a two-entry skid buffer, so downstream back-pressure never has a combinational path into the FIFO increment. It also keeps a running count of delivered words.

## Interface

Parameters:
- DATA_WIDTH, 8, word width; must match the FIFO `width`.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- CLK  in  1  read-domain clock; same clock as the FIFO `rclk`.
- RST  in  1  reset, asynchronous, active-low. In the top level it is driven by the same reset source as the FIFO `rrst`.
- ENABLE  in  1  when high, the block may pop the FIFO. When low, no new pops; buffered words still drain.
- FIFO_EMPTY  in  1  FIFO `rempty`.
- FIFO_RDATA  in  DATA_WIDTH  FIFO `rdata`. First-word-fall-through: valid whenever FIFO_EMPTY=0, and it is the word at the current read pointer.
- FIFO_RINC  out  1  FIFO `rinc`; one word is popped per cycle it is high.
- OUT_DATA  out  DATA_WIDTH  stream data.
- OUT_VALID  out  1  stream valid.
- OUT_READY  in  1  stream ready from the sink.
- WORD_CNT  out  CNT_WIDTH  number of words accepted by the sink, modulo 2^CNT_WIDTH.

## Operation

- Storage consists of a main register (drives OUT_DATA) and a skid register.
- State machine: S_EMPTY (0 words), S_ONE (main valid), S_TWO (main and skid valid).
- push = FIFO_RINC.
  - FIFO_RINC = ENABLE & ~FIFO_EMPTY & (state != S_TWO).
  - FIFO_RINC is decoded from registered state plus the FIFO inputs only. It never depends on OUT_READY.
- pop = OUT_VALID & OUT_READY.
- Transitions:
  - S_EMPTY: push → S_ONE, main <= FIFO_RDATA.
  - S_ONE:
    - push & pop → S_ONE, main <= FIFO_RDATA.
    - push & ~pop → S_TWO, skid <= FIFO_RDATA.
    - ~push & pop → S_EMPTY.
    - neither → hold.
  - S_TWO: pop → S_ONE, main <= skid. ~pop → hold. There is no push in S_TWO.
- OUT_VALID = (state != S_EMPTY), registered-state decode.
- While OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_VALID hold stable.
- Word order is strict FIFO order; no word is dropped or duplicated.
- WORD_CNT increments by 1 on each pop and wraps from all-ones to 0.
- ENABLE deassertion:
  - Takes effect combinationally on FIFO_RINC in the same cycle.
  - Words already in main/skid are still delivered.
  - When it reasserts, popping resumes immediately.
- The block never asserts FIFO_RINC while FIFO_EMPTY=1 (no underflow by construction).

## Timing

- Reset (RST=0, asynchronous) forces state S_EMPTY, main=0, skid=0, WORD_CNT=0.
  - Outputs during reset: OUT_VALID=0, OUT_DATA=0, FIFO_RINC=0 (because state S_EMPTY with ENABLE gating is irrelevant: FIFO_RINC is forced 0 while RST=0).
- Reset mid-operation: buffered words are discarded; no partial transfer is reported.
- Latency: with FIFO_EMPTY=0, ENABLE=1 and state S_EMPTY during cycle k:
  - FIFO_RINC=1 in cycle k.
  - OUT_VALID=1 and OUT_DATA equal to that word from the edge ending cycle k.
- Throughput: one word per cycle sustained while OUT_READY=1 and the FIFO is non-empty (S_ONE with push & pop every cycle).
- Back-pressure: the first stalled cycle still absorbs one pop into skid, then FIFO_RINC=0.
  - After OUT_READY returns, the first cycle drains skid with FIFO_RINC=0.
  - Popping restarts the following cycle. The output stream has no bubble.
- Simultaneous push and pop in S_ONE: the new word replaces main in the same edge, and WORD_CNT increments.
- FIFO_EMPTY rising while in S_ONE/S_TWO has no effect on buffered data.

## Test plan

- Reset, then FIFO_EMPTY=1, ENABLE=1 → OUT_VALID=0, FIFO_RINC=0, WORD_CNT=0 for 10 cycles.
- FIFO holds 0x11,0x22,0x33 and OUT_READY=1 constantly:
  - FIFO_RINC high 3 consecutive cycles.
  - OUT_DATA shows 0x11,0x22,0x33 on consecutive cycles, one cycle after each pop.
  - WORD_CNT ends at 3 and OUT_VALID drops after the last word.
- FIFO holds 8 words 0xA0..0xA7 and OUT_READY low for 5 cycles mid-stream:
  - Exactly one extra pop into skid, then FIFO_RINC=0.
  - OUT_DATA held stable during the stall.
  - After release, all 8 words arrive in order with no gap; WORD_CNT=8.
- ENABLE dropped while in S_TWO, OUT_READY=1 → two buffered words delivered, FIFO_RINC stays 0 until ENABLE=1, then popping resumes.
- CNT_WIDTH=4, 17 words delivered → WORD_CNT wraps to 0 after the 16th word and reads 1 after the 17th.
- RST asserted asynchronously in S_TWO mid-clock → OUT_VALID=0, OUT_DATA=0, WORD_CNT=0 immediately. After release, the next FIFO word is popped normally.
